// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcode/funct
// constants, datapath mux select codes and the decoded instruction-class record.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJump,
    StJr
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnSra = 6'h03;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;

  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;
  localparam logic [1:0] PcRs     = 2'd3;

  localparam logic [1:0] SrcBRt    = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluSub   = 2'd1;
  localparam logic [1:0] AluFunct = 2'd2;

  localparam logic [1:0] DstRt = 2'd0;
  localparam logic [1:0] DstRd = 2'd1;
  localparam logic [1:0] DstRa = 2'd2;

  localparam logic [1:0] WbAluOut = 2'd0;
  localparam logic [1:0] WbMdr    = 2'd1;
  localparam logic [1:0] WbPc     = 2'd2;

  // One-hot instruction class; all zero means unsupported.
  typedef struct packed {
    logic lw;
    logic sw;
    logic rtype;
    logic jr;
    logic itype;
    logic beq;
    logic bne;
    logic j;
    logic jal;
  } instr_class_t;

endpackage

// File: rtl/instr_class.sv
// Combinational decoder: op/funct to one-hot class flags plus the ALU qualifiers
// (signed arithmetic, immediate sign extension, shamt operand).
module instr_class
  import mips_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         illegal,
  output logic         sign,
  output logic         sign_ext,
  output logic         shift
);

  always_comb begin
    cls      = '0;
    illegal  = 1'b0;
    sign     = 1'b0;
    sign_ext = 1'b0;
    shift    = 1'b0;
    case (op)
      OpRtype: begin
        case (funct)
          FnAdd, FnSub: begin
            cls.rtype = 1'b1;
            sign      = 1'b1;
          end
          FnSll, FnSrl, FnSra: begin
            cls.rtype = 1'b1;
            shift     = 1'b1;
          end
          FnJr:    cls.jr  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OpJ:   cls.j   = 1'b1;
      OpJal: cls.jal = 1'b1;
      OpBeq: begin
        cls.beq  = 1'b1;
        sign_ext = 1'b1;
      end
      OpBne: begin
        cls.bne  = 1'b1;
        sign_ext = 1'b1;
      end
      OpLw: begin
        cls.lw   = 1'b1;
        sign_ext = 1'b1;
      end
      OpSw: begin
        cls.sw   = 1'b1;
        sign_ext = 1'b1;
      end
      default: begin
        // 0x08..0x0f: only addi traps and sign-extends its immediate.
        if (op[5:3] == 3'b001) begin
          cls.itype = 1'b1;
          sign      = (op == OpAddi);
          sign_ext  = (op == OpAddi);
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath sharing one memory port and one
// ALU; also counts elapsed cycles and retired instructions.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             sign,
  output logic             sign_ext,
  output logic             shift,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_e       state_q, state_d;
  instr_class_t cls;
  logic         dec_illegal, dec_sign, dec_sign_ext, dec_shift;

  // Attributes latched at DECODE for the later states of the instruction.
  logic       lw_q, beq_q, bne_q, jal_q;
  logic       sign_q, sign_ext_q, shift_q;
  logic [1:0] reg_dst_q;

  instr_class u_instr_class (
    .op       (op),
    .funct    (funct),
    .cls      (cls),
    .illegal  (dec_illegal),
    .sign     (dec_sign),
    .sign_ext (dec_sign_ext),
    .shift    (dec_shift)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lw_q       <= 1'b0;
      beq_q      <= 1'b0;
      bne_q      <= 1'b0;
      jal_q      <= 1'b0;
      sign_q     <= 1'b0;
      sign_ext_q <= 1'b0;
      shift_q    <= 1'b0;
      reg_dst_q  <= DstRt;
    end else if (state_q == StDecode) begin
      lw_q       <= cls.lw;
      beq_q      <= cls.beq;
      bne_q      <= cls.bne;
      jal_q      <= cls.jal;
      sign_q     <= dec_sign;
      sign_ext_q <= dec_sign_ext;
      shift_q    <= dec_shift;
      reg_dst_q  <= cls.rtype ? DstRd : (cls.jal ? DstRa : DstRt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      cycle_count  <= cycle_count + CNT_W'(1);
      retire_count <= retire_count + CNT_W'(retired);
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PcAlu;
    alu_src_a = 1'b0;
    alu_src_b = SrcBRt;
    alu_op    = AluAdd;
    sign      = 1'b0;
    sign_ext  = 1'b0;
    shift     = 1'b0;
    reg_write = 1'b0;
    reg_dst   = DstRt;
    wb_src    = WbAluOut;
    illegal   = 1'b0;
    retired   = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SrcBFour;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = SrcBImmSh;
        if (cls.lw || cls.sw)        state_d = StMemAddr;
        else if (cls.rtype)          state_d = StExecR;
        else if (cls.jr)             state_d = StJr;
        else if (cls.itype)          state_d = StExecI;
        else if (cls.beq || cls.bne) state_d = StBranch;
        else if (cls.j || cls.jal)   state_d = StJump;
        else begin
          illegal = dec_illegal;
          state_d = StFetch;
        end
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        sign_ext  = 1'b1;
        state_d   = lw_q ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mdr_write = mem_ready;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write = 1'b1;
        reg_dst   = DstRt;
        wb_src    = WbMdr;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retired = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBRt;
        alu_op    = AluFunct;
        sign      = sign_q;
        shift     = shift_q;
        reg_dst   = reg_dst_q;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        alu_op    = AluFunct;
        sign      = sign_q;
        sign_ext  = sign_ext_q;
        reg_dst   = reg_dst_q;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = reg_dst_q;
        wb_src    = WbAluOut;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBRt;
        alu_op    = AluSub;
        sign_ext  = 1'b1;
        pc_src    = PcAluOut;
        pc_write  = (beq_q & zero) | (bne_q & ~zero);
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PcJump;
        if (jal_q) begin
          // PC already holds PC+4, which is the link address.
          reg_write = 1'b1;
          reg_dst   = DstRa;
          wb_src    = WbPc;
        end
        retired = 1'b1;
        state_d = StFetch;
      end
      StJr: begin
        pc_write = 1'b1;
        pc_src   = PcRs;
        retired  = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset abandons any in-flight instruction without side effects.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retired   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: retirement expectations are queued at issue
// and checked by a monitor when retired pulses.
module tb_multicycle_control;

  typedef struct {
    int unsigned cyc;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_src;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  op, funct;
  logic        mem_req, mem_write, i_or_d, ir_write, mdr_write, pc_write;
  logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst, wb_src;
  logic        alu_src_a, sign, sign_ext, shift, reg_write, illegal, retired;
  logic [31:0] retire_count, cycle_count;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  logic [31:0] tb_cyc;
  logic [31:0] n_ret = 0;

  multicycle_control #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .mdr_write    (mdr_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .sign         (sign),
    .sign_ext     (sign_ext),
    .shift        (shift),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .wb_src       (wb_src),
    .illegal      (illegal),
    .retired      (retired),
    .retire_count (retire_count),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Reference cycle index: 0 in the first cycle after reset.
  always @(posedge clk) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic pw, input logic [1:0] ps, input logic rw,
                              input logic [1:0] rd, input logic [1:0] wb);
    exp_t e;
    e.cyc       = 0;
    e.pc_write  = pw;
    e.pc_src    = ps;
    e.reg_write = rw;
    e.reg_dst   = rd;
    e.wb_src    = wb;
    return e;
  endfunction

  // Called in a FETCH cycle; returns #1 after the negedge of the next FETCH cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int unsigned lat, input exp_t e);
    e.cyc = tb_cyc + lat - 1;
    sb.push_back(e);
    op        = o;
    funct     = f;
    zero      = z;
    mem_ready = 1'b1;
    repeat (lat) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && retired === 1'b1) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ret_cycle", 64'(tb_cyc), 64'(e.cyc));
        chk("ret_pc_write", 64'(pc_write), 64'(e.pc_write));
        chk("ret_pc_src", 64'(pc_src), 64'(e.pc_src));
        chk("ret_reg_write", 64'(reg_write), 64'(e.reg_write));
        chk("ret_reg_dst", 64'(reg_dst), 64'(e.reg_dst));
        chk("ret_wb_src", 64'(wb_src), 64'(e.wb_src));
      end
      chk("ret_retire_count", 64'(retire_count), 64'(n_ret));
      chk("ret_cycle_count", 64'(cycle_count), 64'(tb_cyc));
      n_ret = n_ret + 1;
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    op        = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;

    // Strobes stay low while reset is held.
    @(negedge clk); #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_ir_write", 64'(ir_write), 64'd0);
    chk("rst_pc_write", 64'(pc_write), 64'd0);
    @(negedge clk); #1;
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch_mem_req", 64'(mem_req), 64'd1);
    chk("fetch_i_or_d", 64'(i_or_d), 64'd0);
    chk("fetch_alu_src_b", 64'(alu_src_b), 64'd1);
    chk("fetch_ir_write", 64'(ir_write), 64'd1);
    chk("fetch_pc_write", 64'(pc_write), 64'd1);
    chk("post_rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("post_rst_retire_count", 64'(retire_count), 64'd0);

    // add with mid-instruction checks
    sb.push_back('{cyc: tb_cyc + 3, pc_write: 1'b0, pc_src: 2'd0, reg_write: 1'b1,
                   reg_dst: 2'd1, wb_src: 2'd0});
    op = 6'h00; funct = 6'h20;
    @(negedge clk); #1;
    chk("add_dec_alu_src_b", 64'(alu_src_b), 64'd3);
    chk("add_dec_illegal", 64'(illegal), 64'd0);
    @(negedge clk); #1;
    chk("add_ex_sign", 64'(sign), 64'd1);
    chk("add_ex_shift", 64'(shift), 64'd0);
    chk("add_ex_alu_op", 64'(alu_op), 64'd2);
    chk("add_ex_reg_dst", 64'(reg_dst), 64'd1);
    @(negedge clk); #1;
    chk("add_wb_retired", 64'(retired), 64'd1);
    @(negedge clk); #1;
    chk("add_retire_count", 64'(retire_count), 64'd1);

    // lw with two wait cycles in MEM_RD
    sb.push_back('{cyc: tb_cyc + 6, pc_write: 1'b0, pc_src: 2'd0, reg_write: 1'b1,
                   reg_dst: 2'd0, wb_src: 2'd1});
    op = 6'h23; funct = 6'h00;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("lw_addr_sign_ext", 64'(sign_ext), 64'd1);
    chk("lw_addr_alu_src_b", 64'(alu_src_b), 64'd2);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("lw_rd_mem_req", 64'(mem_req), 64'd1);
    chk("lw_rd_i_or_d", 64'(i_or_d), 64'd1);
    chk("lw_wait1_mdr_write", 64'(mdr_write), 64'd0);
    @(negedge clk); #1;
    chk("lw_wait2_mdr_write", 64'(mdr_write), 64'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("lw_ready_mdr_write", 64'(mdr_write), 64'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;

    run_instr(6'h00, 6'h03, 1'b0, 4, mk(1'b0, 2'd0, 1'b1, 2'd1, 2'd0)); // sra
    run_instr(6'h08, 6'h00, 1'b0, 4, mk(1'b0, 2'd0, 1'b1, 2'd0, 2'd0)); // addi
    run_instr(6'h0d, 6'h00, 1'b0, 4, mk(1'b0, 2'd0, 1'b1, 2'd0, 2'd0)); // ori
    run_instr(6'h2b, 6'h00, 1'b0, 4, mk(1'b0, 2'd0, 1'b0, 2'd0, 2'd0)); // sw
    run_instr(6'h04, 6'h00, 1'b1, 3, mk(1'b1, 2'd1, 1'b0, 2'd0, 2'd0)); // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 3, mk(1'b0, 2'd1, 1'b0, 2'd0, 2'd0)); // beq not taken
    run_instr(6'h05, 6'h00, 1'b0, 3, mk(1'b1, 2'd1, 1'b0, 2'd0, 2'd0)); // bne taken
    run_instr(6'h05, 6'h00, 1'b1, 3, mk(1'b0, 2'd1, 1'b0, 2'd0, 2'd0)); // bne not taken
    run_instr(6'h02, 6'h00, 1'b0, 3, mk(1'b1, 2'd2, 1'b0, 2'd0, 2'd0)); // j
    run_instr(6'h03, 6'h00, 1'b0, 3, mk(1'b1, 2'd2, 1'b1, 2'd2, 2'd2)); // jal
    run_instr(6'h00, 6'h08, 1'b0, 3, mk(1'b1, 2'd3, 1'b0, 2'd0, 2'd0)); // jr

    // Unsupported opcode and unsupported funct
    op = 6'h3f; funct = 6'h00;
    @(negedge clk); #1;
    chk("ill_op_pulse", 64'(illegal), 64'd1);
    chk("ill_op_retired", 64'(retired), 64'd0);
    @(negedge clk); #1;
    chk("ill_op_back_fetch", 64'(mem_req), 64'd1);
    chk("ill_op_illegal_low", 64'(illegal), 64'd0);
    chk("ill_op_retire_count", 64'(retire_count), 64'(n_ret));
    op = 6'h00; funct = 6'h21;
    @(negedge clk); #1;
    chk("ill_fn_pulse", 64'(illegal), 64'd1);
    @(negedge clk); #1;
    chk("ill_fn_retire_count", 64'(retire_count), 64'(n_ret));
    chk("cycle_count_model", 64'(cycle_count), 64'(tb_cyc));

    // sw abandoned by reset while waiting in MEM_WR
    op = 6'h2b; funct = 6'h00;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sw_wait_mem_write", 64'(mem_write), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("sw_rst_mem_write", 64'(mem_write), 64'd0);
    chk("sw_rst_mem_req", 64'(mem_req), 64'd0);
    n_ret = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("sw_rst_fetch_mem_req", 64'(mem_req), 64'd1);
    chk("sw_rst_fetch_mem_write", 64'(mem_write), 64'd0);
    chk("sw_rst_fetch_i_or_d", 64'(i_or_d), 64'd0);
    chk("sw_rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("sw_rst_retire_count", 64'(retire_count), 64'd0);
    mem_ready = 1'b1;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. A single unified memory port is shared between instruction fetch and data access, and one ALU is reused for PC+4, address calculation and branch targets. A Moore FSM steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states, and it waits on a memory ready handshake. It covers the same instruction set as the single-cycle control unit, and it also keeps a retired-instruction counter for performance monitoring.

Parameters:
CNT_W, 32, width of retire_count and cycle_count.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
op  in  6  opcode from instruction register (IR); valid from DECODE onward
funct  in  6  funct field from IR
zero  in  1  ALU zero flag, valid in the same cycle it is used
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request; held until mem_ready
mem_write  out  1  request is a store (qualifies mem_req)
i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR from memory read data
mdr_write  out  1  load MDR from memory read data
pc_write  out  1  update PC this cycle
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = immediate, 3 = immediate<<2
alu_op  out  2  0 = add, 1 = sub, 2 = use funct
sign  out  1  signed (trapping) arithmetic
sign_ext  out  1  sign-extend immediate (0 = zero-extend)
shift  out  1  ALU A operand = shamt
reg_write  out  1  register file write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
wb_src  out  2  0 = ALUOut, 1 = MDR, 2 = PC
illegal  out  1  one-cycle pulse on an unsupported instruction
retired  out  1  one-cycle pulse when an instruction completes
retire_count  out  CNT_W  number of retired instructions
cycle_count  out  CNT_W  number of cycles since reset

Behaviour:
- Reset is synchronous, sampled on rising clk.
  - Forces state to FETCH and clears both counters to 0.
  - While reset is high, all strobes (mem_req, mem_write, ir_write, mdr_write, pc_write, reg_write, illegal, retired) are 0.
  - Reset asserted mid-instruction abandons the instruction. No writes occur in that cycle.
- Outputs are decoded from the state register plus the qualifiers listed below. Unlisted outputs are 0 in each state.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
  - ir_write and pc_write are asserted only when mem_ready=1. The FSM then goes to DECODE; otherwise it stays in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=add. This computes the branch target into ALUOut.
  - Next state by class:
    - lw/sw -> MEM_ADDR
    - R-type (add, sub, sll, srl, sra) -> EXEC_R
    - jr -> JR
    - I-type ALU (op 0x08..0x0f) -> EXEC_I
    - beq/bne -> BRANCH
    - j/jal -> JUMP
    - other -> FETCH, with illegal=1 and no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, sign_ext=1, alu_op=add. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, i_or_d=1, mdr_write=mem_ready. Goes to MEM_WB on mem_ready, else stays.
- MEM_WB: reg_write=1, reg_dst=0, wb_src=1, retired=1. Goes to FETCH.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. On mem_ready: retired=1, goes to FETCH; else stays.
- EXEC_R:
  - alu_src_a=1, alu_src_b=0, alu_op=funct.
  - sign is 1 for add and sub. shift is 1 for sll, srl and sra.
  - Goes to ALU_WB with reg_dst=1.
- EXEC_I:
  - alu_src_a=1, alu_src_b=2, alu_op=funct-equivalent, sign=addi, sign_ext=addi.
  - Goes to ALU_WB with reg_dst=0.
- ALU_WB: reg_write=1, wb_src=0, retired=1. reg_dst is held per the latched class. Goes to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=sub, sign_ext=1, pc_src=1.
  - pc_write = (beq & zero) | (bne & !zero).
  - retired=1. Goes to FETCH.
- JUMP: pc_write=1, pc_src=2. For jal only: reg_write=1, reg_dst=2, wb_src=2 (PC is already PC+4). retired=1. Goes to FETCH.
- JR: pc_write=1, pc_src=3, retired=1. Goes to FETCH.
- Class and reg_dst are latched at DECODE; op and funct are stable after IR load.
- Latency with zero-wait memory:
  - beq, bne, j, jal, jr: 3 cycles
  - R-type, I-type ALU: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds 1.
- Counters:
  - cycle_count increments every non-reset cycle.
  - retire_count increments when retired=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package (mips_pkg):
  - state encodings
  - opcode and funct constants
  - pc_src, alu_src_b, alu_op, reg_dst and wb_src select codes
- One combinational sub-module, instr_class: maps op/funct to one-hot class flags plus sign, sign_ext and shift.

Test Plan:
- reset held 2 cycles, released, mem_ready=1 -> state FETCH, mem_req=1, counters 0. ir_write and pc_write pulse in the first post-reset cycle.
- add (op 0x00, funct 0x20), mem_ready always 1 -> retired on cycle 4. reg_write=1, reg_dst=1, sign=1. retire_count=1.
- lw (op 0x23) with mem_ready low 2 cycles in MEM_RD -> mdr_write only on the ready cycle. Retires on cycle 7 (5 + 2 waits), reg_dst=0, wb_src=1.
- Branch cases, each retiring in 3 cycles:
  - beq (op 0x04) with zero=1 -> pc_write=1, pc_src=1.
  - beq with zero=0 -> pc_write=0.
  - bne (op 0x05) with zero=0 -> pc_write=1.
- jal (op 0x03) -> pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_src=2. jr (funct 0x08) -> pc_src=3.
- op 0x3f -> illegal pulse in DECODE, returns to FETCH, retire_count unchanged. Reset asserted during MEM_WR wait -> no mem_write next cycle, state FETCH.
